dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the RV32I single-cycle core; it is the memory end of the load handshake whose `dmem_valid` stalls the program counter.
- Accepts load/store requests from the core's LSU. Stores commit in one cycle. Loads return sign- or zero-extended data after a fixed, parameterised wait-state latency, signalled by a one-cycle `dmem_valid` pulse.
- Sits between the core datapath and the on-chip data RAM array (held internally).

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two.
- LOAD_LATENCY, 2, cycles from load acceptance to the `dmem_valid` pulse; legal range 1..15.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-low.
- load  input  1  load request; core holds it high until `dmem_valid`.
- store  input  1  store request; single-cycle.
- addr  input  32  byte address.
- wdata  input  32  store data, LSB-aligned.
- funct3  input  3  access size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- rdata  output  32  extended load data; valid while `dmem_valid` is high.
- dmem_valid  output  1  one-cycle load-completion pulse.
- misalign  output  1  one-cycle pulse flagging a misaligned or illegal access.

Behaviour:
- Reset (rst low, async): state=IDLE, `dmem_valid`=0, `rdata`=0, `misalign`=0, latency counter=0. RAM contents are not cleared.
- Reset mid-transaction: the transaction is abandoned and no pulse is produced after release.
- Word index is `addr[2 +: log2(DEPTH_WORDS)]`. Upper address bits are ignored, so addresses alias (wrap).
- FSM has three states: IDLE, WAIT, RESP.
- IDLE, load=1 at clock edge:
  - latch `addr` and `funct3`;
  - if LOAD_LATENCY=1, go to RESP;
  - otherwise go to WAIT with counter=LOAD_LATENCY-1.
- WAIT:
  - counter decrements each edge; at counter=1 the next state is RESP;
  - if load drops while in WAIT, abort to IDLE with no `dmem_valid` pulse.
- RESP:
  - `dmem_valid`=1 and `rdata` is driven for exactly this cycle;
  - next state is IDLE unconditionally.
  - A load seen on the cycle after RESP is a new request and is accepted.
- Latency contract: load first high in cycle T (state IDLE) gives `dmem_valid` high in cycle T+LOAD_LATENCY. The core's PC therefore holds for LOAD_LATENCY cycles and advances at the end of the RESP cycle.
- RAM read: the RAM is read on the edge entering RESP using the latched address, and registered into `rdata`.
- Load extraction and extension:
  - Byte select is `addr[1:0]`; halfword select is `addr[1]`.
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend.
  - W returns the full word.
- Store (IDLE only, store=1, load=0):
  - RAM is written at that edge with byte enables: B writes lane `addr[1:0]` with `wdata[7:0]`; H writes lanes `{addr[1],0}` and `{addr[1],1}` with `wdata[15:0]`; W writes all lanes.
  - No `dmem_valid` is generated.
  - Store-then-load to the same address in back-to-back cycles returns the new data.
- Misalignment:
  - Misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. funct3 011, 110 or 111 is illegal and is treated like a misaligned access.
  - Misaligned store: the write is suppressed and `misalign` pulses in the cycle after the edge.
  - Misaligned load: completes normally with the same latency, `rdata`=0, and `misalign`=1 in the RESP cycle.
- Simultaneous load and store in IDLE: the load has priority, the store is dropped, and `misalign` pulses in the next cycle.
- store=1 while in WAIT or RESP: ignored, no write.
- `dmem_valid` and `misalign` never stay high for two consecutive cycles from one request.

Test Plan:
- Reset/idle: hold rst low for 3 cycles, release, keep load=0 and store=0 for 10 cycles -> `dmem_valid`=0, `rdata`=0, `misalign`=0 throughout.
- Word path: store W 0xDEADBEEF at 0x10 in cycle 0; load W at 0x10 from cycle 1 with LOAD_LATENCY=2 -> `dmem_valid` high only in cycle 3 with `rdata`=0xDEADBEEF.
- Extension, RAM word 0x8001F07F at 0x20:
  - LB at 0x20 -> 0x0000007F.
  - LB at 0x21 -> 0xFFFFFFF0.
  - LBU at 0x21 -> 0x000000F0.
  - LH at 0x22 -> 0xFFFF8001.
  - LHU at 0x22 -> 0x00008001.
- Byte-enable store: RAM word 0x00000000 at 0x30; SB 0xAB at 0x33, then SH 0x1234 at 0x30 -> LW at 0x30 returns 0xAB001234.
- Misalignment:
  - LW at 0x42 -> `dmem_valid` and `misalign` both high in the RESP cycle, `rdata`=0.
  - SH at 0x41 -> `misalign` pulses in the next cycle and the word at 0x40 is unchanged.
- Abort, reset and wrap (LOAD_LATENCY=3):
  - Drop load in cycle T+1 -> no pulse, and a new load at T+3 completes at T+6.
  - Assert rst in WAIT -> no pulse after release.
  - With DEPTH_WORDS=1024, store to 0x1000 -> LW at 0x0 returns the stored data.

Source files
------------

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the RV32I single-cycle core. It owns the on-chip
// data RAM and answers the LSU's load/store requests. Stores commit on the
// edge they are seen. Loads return sign- or zero-extended data a fixed
// LOAD_LATENCY cycles after acceptance, flagged by a one-cycle dmem_valid
// pulse. The core holds its PC while waiting for that pulse.
//
// Parameters:
//   DEPTH_WORDS  - number of 32-bit RAM words (power of two)
//   LOAD_LATENCY - cycles from load acceptance to dmem_valid (1..15)
//
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset
//   load       - load request, held high by the core until dmem_valid
//   store      - single-cycle store request
//   addr       - byte address (upper bits beyond the RAM alias)
//   wdata      - store data, LSB-aligned
//   funct3     - access size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   rdata      - extended load data, valid while dmem_valid is high
//   dmem_valid - one-cycle load-completion pulse
//   misalign   - one-cycle pulse for a misaligned or illegal access
// ----------------------------------------------------------------------------
module dmem_responder #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int LOAD_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        store,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        dmem_valid,
    output logic        misalign
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [AW+1:0]  addr_q;
    logic [2:0]     funct3_q;
    logic [31:0]    rdata_q, rdata_d;
    logic           misalign_q, misalign_d;

    logic [31:0]    mem [DEPTH_WORDS];

    logic [AW+1:0]  rdAddr;
    logic [2:0]     rdFunct3;
    logic [31:0]    rdWord;
    logic [7:0]     rdByte;
    logic [15:0]    rdHalf;
    logic [31:0]    loadData;
    logic           enterResp;
    logic           storeIdle;
    logic           acceptLoad;
    logic           wrEn;
    logic [3:0]     byteEn;
    logic [31:0]    wrData;
    logic           unusedAddrBits;

    // Address bits above the RAM size are deliberately ignored (aliasing).
    assign unusedAddrBits = ^addr[31:AW+2];

    // Illegal funct3 codes are folded into the misaligned category.
    function automatic logic isIllegal(input logic [2:0] f, input logic [1:0] a);
        logic bad;
        case (f)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = a[0];
            3'b010:         bad = (a != 2'b00);
            default:        bad = 1'b1;
        endcase
        return bad;
    endfunction

    // With LOAD_LATENCY=1 the RAM is read on the accepting edge itself, before
    // addr_q holds the request, so the live inputs are used while IDLE.
    assign rdAddr   = (state_q == IDLE) ? addr[AW+1:0] : addr_q;
    assign rdFunct3 = (state_q == IDLE) ? funct3 : funct3_q;
    assign rdWord   = mem[rdAddr[AW+1:2]];
    assign rdByte   = rdWord[{rdAddr[1:0], 3'b000} +: 8];
    assign rdHalf   = rdWord[{rdAddr[1], 4'b0000} +: 16];

    // Load extraction and sign/zero extension.
    always_comb begin
        loadData = '0;
        case (rdFunct3)
            3'b000:  loadData = {{24{rdByte[7]}}, rdByte};
            3'b100:  loadData = {24'h0, rdByte};
            3'b001:  loadData = {{16{rdHalf[15]}}, rdHalf};
            3'b101:  loadData = {16'h0, rdHalf};
            3'b010:  loadData = rdWord;
            default: loadData = '0;
        endcase
    end

    // Next-state logic. A dropped load while waiting abandons the request.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    if (LOAD_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = 4'(LOAD_LATENCY - 1);
                    end
                end
            end
            WAIT: begin
                if (!load) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign enterResp  = (state_d == RESP);
    assign storeIdle  = (state_q == IDLE) && store;
    assign acceptLoad = (state_q == IDLE) && load;
    assign wrEn       = storeIdle && !load && !isIllegal(funct3, addr[1:0]);

    // rdata is only non-zero in the RESP cycle; misaligned loads return zero.
    // misalign covers a bad load (in RESP), a bad store, or a store dropped
    // because a load took priority.
    assign rdata_d    = (enterResp && !isIllegal(rdFunct3, rdAddr[1:0])) ? loadData : '0;
    assign misalign_d = (enterResp && isIllegal(rdFunct3, rdAddr[1:0]))
                      || (storeIdle && (load || isIllegal(funct3, addr[1:0])));

    // Store lane selection; data is replicated so each enabled lane sees its byte.
    always_comb begin
        byteEn = 4'b0000;
        wrData = wdata;
        case (funct3)
            3'b000: begin
                byteEn = 4'b0001 << addr[1:0];
                wrData = {4{wdata[7:0]}};
            end
            3'b001: begin
                byteEn = addr[1] ? 4'b1100 : 4'b0011;
                wrData = {2{wdata[15:0]}};
            end
            3'b010: begin
                byteEn = 4'b1111;
            end
            default: byteEn = 4'b0000;
        endcase
    end

    // RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) begin
                    mem[addr[AW+1:2]][8*i +: 8] <= wrData[8*i +: 8];
                end
            end
        end
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            funct3_q   <= '0;
            rdata_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            if (acceptLoad) begin
                addr_q   <= addr[AW+1:0];
                funct3_q <= funct3;
            end
        end
    end

    assign dmem_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign misalign   = misalign_q;

endmodule

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder
//
// Drives two responders sharing store/addr/wdata/funct3 but with separate
// load lines: inst 0 uses LOAD_LATENCY=2, inst 1 uses LOAD_LATENCY=3.
// A byte-level memory model predicts every output each cycle; directed
// loads also carry hand-computed expected data.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load0 = 1'b0;
    logic        load1 = 1'b0;
    logic        store = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] rd0, rd1;
    logic        dv0, dv1, ms0, ms1;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit checking = 1'b0;

    int          lat [2] = '{2, 3};
    logic [7:0]  mdl [2][4096];
    bit          busy [2];
    bit          respNow [2];
    int          respCyc [2];
    logic [31:0] la [2];
    logic [2:0]  lf [2];
    bit          expV [2];
    bit          expM [2];
    logic [31:0] expRd [2];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(1024), .LOAD_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .load(load0), .store(store), .addr(addr),
        .wdata(wdata), .funct3(funct3), .rdata(rd0), .dmem_valid(dv0),
        .misalign(ms0)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LOAD_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .load(load1), .store(store), .addr(addr),
        .wdata(wdata), .funct3(funct3), .rdata(rd1), .dmem_valid(dv1),
        .misalign(ms1)
    );

    function automatic logic dvOf(input int k);
        return (k == 0) ? dv0 : dv1;
    endfunction

    function automatic logic msOf(input int k);
        return (k == 0) ? ms0 : ms1;
    endfunction

    function automatic logic [31:0] rdOf(input int k);
        return (k == 0) ? rd0 : rd1;
    endfunction

    function automatic logic loadOf(input int k);
        return (k == 0) ? load0 : load1;
    endfunction

    task automatic setLoad(input int k, input logic v);
        if (k == 0) load0 = v;
        else load1 = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Access legality from the ISA rules on size and alignment.
    function automatic bit illegalAcc(input logic [2:0] f, input logic [31:0] a);
        case (f)
            3'b000, 3'b100: return 1'b0;
            3'b001, 3'b101: return (a % 2) != 0;
            3'b010:         return (a % 4) != 0;
            default:        return 1'b1;
        endcase
    endfunction

    // Value a load must return, built from the model's byte array.
    function automatic logic [31:0] loadVal(input int k, input logic [31:0] a, input logic [2:0] f);
        int b;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] w;
        b  = int'(a % 32'd4096);
        by = mdl[k][b];
        hw = {mdl[k][(b + 1) % 4096], mdl[k][b]};
        w  = {mdl[k][(b + 3) % 4096], mdl[k][(b + 2) % 4096], mdl[k][(b + 1) % 4096], mdl[k][b]};
        case (f)
            3'b000:  return {{24{by[7]}}, by};
            3'b100:  return {24'h0, by};
            3'b001:  return {{16{hw[15]}}, hw};
            3'b101:  return {16'h0, hw};
            3'b010:  return w;
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelStore(input int k, input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd);
        int b;
        b = int'(a % 32'd4096);
        if (f == 3'b000) begin
            mdl[k][b] = wd[7:0];
        end else if (f == 3'b001) begin
            mdl[k][b]     = wd[7:0];
            mdl[k][b + 1] = wd[15:8];
        end else begin
            for (int i = 0; i < 4; i++) mdl[k][b + i] = wd[8*i +: 8];
        end
    endtask

    task automatic respond(input int k);
        expV[k]    = 1'b1;
        busy[k]    = 1'b0;
        respNow[k] = 1'b1;
        if (illegalAcc(lf[k], la[k])) begin
            expM[k]  = 1'b1;
            expRd[k] = 32'h0;
        end else begin
            expRd[k] = loadVal(k, la[k], lf[k]);
        end
    endtask

    // At each edge, predict the outputs for the cycle that follows.
    task automatic modelStep();
        for (int k = 0; k < 2; k++) begin
            expV[k]  = 1'b0;
            expM[k]  = 1'b0;
            expRd[k] = 32'h0;
            if (!rst) begin
                busy[k]    = 1'b0;
                respNow[k] = 1'b0;
            end else if (respNow[k]) begin
                respNow[k] = 1'b0;
            end else if (busy[k]) begin
                if (!loadOf(k)) busy[k] = 1'b0;
                else if (cyc + 1 == respCyc[k]) respond(k);
            end else if (loadOf(k)) begin
                busy[k]    = 1'b1;
                respCyc[k] = cyc + lat[k];
                la[k]      = addr;
                lf[k]      = funct3;
                if (store) expM[k] = 1'b1;
                if (cyc + 1 == respCyc[k]) respond(k);
            end else if (store) begin
                if (illegalAcc(funct3, addr)) expM[k] = 1'b1;
                else modelStore(k, addr, funct3, wdata);
            end
        end
        cyc++;
    endtask

    initial forever begin
        @(posedge clk);
        modelStep();
    end

    // Compare every output of both instances against the model each cycle.
    initial forever begin
        @(negedge clk);
        if (checking) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("dmem_valid[%0d]", k), 32'(dvOf(k)), rst ? 32'(expV[k]) : 32'd0);
                checkOutput($sformatf("misalign[%0d]", k), 32'(msOf(k)), rst ? 32'(expM[k]) : 32'd0);
                checkOutput($sformatf("rdata[%0d]", k), rdOf(k), rst ? expRd[k] : 32'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One load (optionally with a simultaneous store) or one store.
    task automatic applyStimulus(input int k, input bit doLoad, input bit doStore,
                                 input logic [31:0] a, input logic [2:0] f, input logic [31:0] wd,
                                 input logic [31:0] expData, input bit expMis);
        int t0;
        bit seen;
        addr   = a;
        funct3 = f;
        wdata  = wd;
        store  = doStore;
        if (doLoad) begin
            setLoad(k, 1'b1);
            t0   = cyc;
            seen = 1'b0;
            tick();
            store = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                if (dvOf(k)) seen = 1'b1;
                else tick();
            end
            if (seen) begin
                checkOutput("loadLatency", 32'(cyc - t0), 32'(lat[k]));
                checkOutput("loadData", rdOf(k), expData);
                checkOutput("loadMisalign", 32'(msOf(k)), 32'(expMis));
            end else begin
                checkOutput("loadTimeout", 32'(dvOf(k)), 32'd1);
            end
            setLoad(k, 1'b0);
            tick();
        end else begin
            tick();
            store = 1'b0;
            checkOutput("storeMisalign0", 32'(ms0), 32'(expMis));
            checkOutput("storeMisalign1", 32'(ms1), 32'(expMis));
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1;
        rst = 1'b0;
        checking = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        repeat (10) tick();
        checkOutput("idleRdata", rd0, 32'h0);
        checkOutput("idleValid", 32'(dv1), 32'h0);

        // Word path: store then back-to-back load
        applyStimulus(0, 0, 1, 32'h10, 3'b010, 32'hDEADBEEF, 32'h0, 1'b0);
        applyStimulus(0, 1, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Extension cases
        applyStimulus(0, 0, 1, 32'h20, 3'b010, 32'h8001F07F, 32'h0, 1'b0);
        applyStimulus(0, 1, 0, 32'h20, 3'b000, 32'h0, 32'h0000007F, 1'b0);
        applyStimulus(1, 1, 0, 32'h21, 3'b000, 32'h0, 32'hFFFFFFF0, 1'b0);
        applyStimulus(0, 1, 0, 32'h21, 3'b100, 32'h0, 32'h000000F0, 1'b0);
        applyStimulus(1, 1, 0, 32'h22, 3'b001, 32'h0, 32'hFFFF8001, 1'b0);
        applyStimulus(0, 1, 0, 32'h22, 3'b101, 32'h0, 32'h00008001, 1'b0);

        // Byte-enable stores
        applyStimulus(0, 0, 1, 32'h30, 3'b010, 32'h00000000, 32'h0, 1'b0);
        applyStimulus(0, 0, 1, 32'h33, 3'b000, 32'h55AA66AB, 32'h0, 1'b0);
        applyStimulus(0, 0, 1, 32'h30, 3'b001, 32'h99991234, 32'h0, 1'b0);
        applyStimulus(1, 1, 0, 32'h30, 3'b010, 32'h0, 32'hAB001234, 1'b0);

        // Misalignment and illegal funct3
        applyStimulus(0, 1, 0, 32'h42, 3'b010, 32'h0, 32'h0, 1'b1);
        applyStimulus(0, 0, 1, 32'h40, 3'b010, 32'h11223344, 32'h0, 1'b0);
        applyStimulus(0, 0, 1, 32'h41, 3'b001, 32'h0000BEEF, 32'h0, 1'b1);
        applyStimulus(1, 1, 0, 32'h40, 3'b010, 32'h0, 32'h11223344, 1'b0);
        applyStimulus(0, 0, 1, 32'h10, 3'b111, 32'h0, 32'h0, 1'b1);
        applyStimulus(1, 1, 0, 32'h10, 3'b011, 32'h0, 32'h0, 1'b1);
        applyStimulus(0, 1, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Load+store together: inst 0 drops the store, idle inst 1 takes it
        applyStimulus(0, 0, 1, 32'h50, 3'b010, 32'h0BADF00D, 32'h0, 1'b0);
        applyStimulus(0, 1, 1, 32'h50, 3'b010, 32'h12345678, 32'h0BADF00D, 1'b0);
        applyStimulus(0, 1, 0, 32'h50, 3'b010, 32'h0, 32'h0BADF00D, 1'b0);
        applyStimulus(1, 1, 0, 32'h50, 3'b010, 32'h0, 32'h12345678, 1'b0);

        // Abort on the latency-3 instance: drop in T+1, reload at T+3
        addr   = 32'h10;
        funct3 = 3'b010;
        load1  = 1'b1;
        tick();
        load1 = 1'b0;
        tick();
        tick();
        checkOutput("abortNoPulse", 32'(dv1), 32'h0);
        applyStimulus(1, 1, 0, 32'h10, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0);

        // Reset while waiting: no pulse afterwards, RAM retained
        addr   = 32'h20;
        funct3 = 3'b010;
        load1  = 1'b1;
        tick();
        tick();
        rst   = 1'b0;
        load1 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("rstNoPulse", 32'(dv1), 32'h0);
            tick();
        end
        applyStimulus(1, 1, 0, 32'h20, 3'b010, 32'h0, 32'h8001F07F, 1'b0);

        // Address aliasing above the RAM size
        applyStimulus(0, 0, 1, 32'h1000, 3'b010, 32'hCAFEF00D, 32'h0, 1'b0);
        applyStimulus(0, 1, 0, 32'h0, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);
        applyStimulus(1, 1, 0, 32'h0, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

        repeat (4) tick();
        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
